// File: rtl/score_display.sv
// Score keeping and seven-segment output: counts pipes cleared by the bird in
// BCD, tracks the best score, and multiplexes the live score onto four digits.
module score_display #(
    parameter logic [9:0] PIPE_WIDTH   = 10'd60,
    parameter int         REFRESH_BITS = 18
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Lost,
    input  logic [9:0]  PipeX1,
    input  logic [9:0]  PipeX2,
    input  logic [9:0]  BirdX,
    output logic [15:0] score,
    output logic [15:0] best,
    output logic [6:0]  ssdOut,
    output logic [3:0]  anode
);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t                  state, nextState;
    logic                    startQ, startRise;
    logic                    pass1, pass2, passPrev1, passPrev2;
    logic                    ev1, ev2;
    logic [1:0]              incAmt;
    logic [15:0]             scoreNext, bestNext;
    logic [REFRESH_BITS-1:0] refreshCnt;
    logic [1:0]              sel;
    logic [3:0]              digit;
    logic                    blank;

    // Ripple BCD add of 0..2; any carry out of the thousands digit saturates.
    function automatic logic [15:0] bcdAdd(input logic [15:0] v, input logic [1:0] inc);
        logic [15:0] r;
        logic [4:0]  d;
        logic [1:0]  c;
        r = '0;
        c = inc;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, v[4*i +: 4]} + {3'b000, c};
            if (d > 5'd9) begin
                r[4*i +: 4] = 4'(d - 5'd10);
                c = 2'd1;
            end else begin
                r[4*i +: 4] = d[3:0];
                c = 2'd0;
            end
        end
        return (c != 2'd0) ? 16'h9999 : r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign startRise = Start & ~startQ;
    assign pass1     = ({1'b0, PipeX1} + {1'b0, PIPE_WIDTH}) < {1'b0, BirdX};
    assign pass2     = ({1'b0, PipeX2} + {1'b0, PIPE_WIDTH}) < {1'b0, BirdX};
    assign ev1       = pass1 & ~passPrev1;
    assign ev2       = pass2 & ~passPrev2;
    assign incAmt    = {1'b0, ev1} + {1'b0, ev2};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (startRise) nextState = PLAY;
            PLAY:    if (Lost)      nextState = OVER;
            OVER:    if (startRise) nextState = PLAY;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        scoreNext = score;
        bestNext  = best;
        case (state)
            IDLE: scoreNext = 16'h0000;
            PLAY: begin
                // Lost wins over a same-cycle pass; BCD orders like binary.
                if (Lost) begin
                    if (score > best) bestNext = score;
                end else if (incAmt != 2'd0) begin
                    scoreNext = bcdAdd(score, incAmt);
                end
            end
            OVER: if (startRise) scoreNext = 16'h0000;
            default: scoreNext = 16'h0000;
        endcase
    end

    // Pass history follows every cycle, so entering PLAY arms on the current view.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            score     <= 16'h0000;
            best      <= 16'h0000;
            startQ    <= 1'b0;
            passPrev1 <= 1'b0;
            passPrev2 <= 1'b0;
        end else begin
            score     <= scoreNext;
            best      <= bestNext;
            startQ    <= Start;
            passPrev1 <= pass1;
            passPrev2 <= pass2;
        end
    end

    assign sel   = refreshCnt[REFRESH_BITS-1 -: 2];
    assign digit = score[4*sel +: 4];

    always_comb begin
        blank = 1'b0;
        case (sel)
            2'd1: blank = (score[15:4]  == 12'h000);
            2'd2: blank = (score[15:8]  == 8'h00);
            2'd3: blank = (score[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            refreshCnt <= '0;
            anode      <= 4'b1110;
            ssdOut     <= 7'b0000001;
        end else begin
            refreshCnt <= refreshCnt + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
            anode      <= blank ? 4'b1111 : ~(4'b0001 << sel);
            ssdOut     <= blank ? 7'b1111111 : seg7(digit);
        end
    end

endmodule
